// File: rtl/icache_pkg.sv
// Shared configuration for the instruction cache: FSM state encodings and
// default geometry.
package icache_pkg;

  localparam int ICACHE_INDEX_BITS = 6;

  typedef enum logic [0:0] {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// miss. Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic        IF_valid,
  output logic [31:0] IF_addr,
  input  logic        IF_send,
  input  logic [31:0] IF_inst
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`else
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 16 - INDEX_BITS;

  logic [LINES-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_r  [LINES];
  logic [31:0]         data_r [LINES];

  icache_state_e state_r, state_s;
  logic          fetch_ready_r, fetch_ready_s;
  logic [31:0]   fetch_inst_r, fetch_inst_s;
  logic          if_valid_r, if_valid_s;
  logic [31:0]   if_addr_r, if_addr_s;
  logic          wr_en_s;
  logic          hit_inc_s, miss_inc_s;

  logic [INDEX_BITS-1:0] look_idx_s, fill_idx_s;
  logic [TAG_BITS-1:0]   look_tag_s, fill_tag_s;
  logic                  hit_s;
  logic                  unused_addr_s;

  // Lookup uses the live fetch address; the refill uses the latched miss address.
  assign look_idx_s    = fetch_addr[INDEX_BITS+1:2];
  assign look_tag_s    = fetch_addr[17:INDEX_BITS+2];
  assign fill_idx_s    = if_addr_r[INDEX_BITS+1:2];
  assign fill_tag_s    = if_addr_r[17:INDEX_BITS+2];
  assign hit_s         = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
  assign unused_addr_s = ^fetch_addr[1:0];

  // Next-state and next-output logic; rst, then jump_rst, then rdy take priority.
  always_comb begin
    state_s       = state_r;
    fetch_ready_s = 1'b0;
    fetch_inst_s  = fetch_inst_r;
    if_valid_s    = if_valid_r;
    if_addr_s     = if_addr_r;
    wr_en_s       = 1'b0;
    hit_inc_s     = 1'b0;
    miss_inc_s    = 1'b0;
    if (rst) begin
      state_s = ICACHE_IDLE;
    end else if (jump_rst) begin
      state_s    = ICACHE_IDLE;
      if_valid_s = 1'b0;
    end else if (!rdy) begin
      fetch_ready_s = fetch_ready_r;
    end else begin
      case (state_r)
        ICACHE_IDLE: begin
          // The ready cycle still shows the old request, so it must not be re-served.
          if (fetch_valid && !fetch_ready_r) begin
            if (hit_s) begin
              fetch_ready_s = 1'b1;
              fetch_inst_s  = data_r[look_idx_s];
              hit_inc_s     = 1'b1;
            end else begin
              state_s    = ICACHE_MISS;
              if_valid_s = 1'b1;
              if_addr_s  = {fetch_addr[31:2], 2'b00};
              miss_inc_s = 1'b1;
            end
          end else begin
            state_s = ICACHE_IDLE;
          end
        end
        ICACHE_MISS: begin
          if (IF_send) begin
            state_s       = ICACHE_IDLE;
            wr_en_s       = 1'b1;
            if_valid_s    = 1'b0;
            fetch_ready_s = 1'b1;
            fetch_inst_s  = IF_inst;
          end else begin
            state_s = ICACHE_MISS;
          end
        end
        default: begin
          state_s    = ICACHE_IDLE;
          if_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State, output and valid-bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ICACHE_IDLE;
      valid_r       <= {LINES{1'b0}};
      fetch_ready_r <= 1'b0;
      fetch_inst_r  <= 32'h0000_0000;
      if_valid_r    <= 1'b0;
      if_addr_r     <= 32'h0000_0000;
    end else begin
      state_r       <= state_s;
      fetch_ready_r <= fetch_ready_s;
      fetch_inst_r  <= fetch_inst_s;
      if_valid_r    <= if_valid_s;
      if_addr_r     <= if_addr_s;
      if (wr_en_s) begin
        valid_r[fill_idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tag_r[fill_idx_s]  <= fill_tag_s;
      data_r[fill_idx_s] <= IF_inst;
    end
  end

  assign fetch_ready = fetch_ready_r;
  assign fetch_inst  = fetch_inst_r;
  assign IF_valid    = if_valid_r;
  assign IF_addr     = if_addr_r;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Lookup counters; they wrap naturally and only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= 32'h0000_0000;
      miss_cnt_r <= 32'h0000_0000;
    end else begin
      if (hit_inc_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_inc_s) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = hit_inc_s ^ miss_inc_s;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a transaction-level cache model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_icache;

  localparam int IB    = 6;
  localparam int LINES = 1 << IB;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_rst, fetch_valid, IF_send;
  logic [31:0] fetch_addr, IF_inst;
  logic        fetch_ready, IF_valid;
  logic [31:0] fetch_inst, IF_addr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  icache #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_inst(fetch_inst),
    .IF_valid(IF_valid), .IF_addr(IF_addr),
    .IF_send(IF_send), .IF_inst(IF_inst)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: cache lines keyed by index, one pending miss, expected outputs.
  bit          m_live = 1'b0;
  bit          m_valid [int];
  int          m_tag   [int];
  logic [31:0] m_data  [int];
  bit          pend;
  logic [31:0] pend_addr;
  logic        exp_ready, exp_ifv;
  logic [31:0] exp_inst, exp_ifa;
  int          m_hits, m_misses;

  always @(posedge clk) begin
    int line;
    bit was_ready;
    if (rst) begin
      m_valid.delete();
      pend = 1'b0; exp_ready = 1'b0; exp_ifv = 1'b0;
      exp_inst = 32'h0; exp_ifa = 32'h0;
      m_hits = 0; m_misses = 0; m_live = 1'b1;
    end else if (jump_rst) begin
      pend = 1'b0; exp_ready = 1'b0; exp_ifv = 1'b0;
    end else if (!rdy) begin
      // everything frozen
    end else if (pend) begin
      if (IF_send) begin
        line = int'(pend_addr[17:2]);
        m_valid[line % LINES] = 1'b1;
        m_tag[line % LINES]   = line / LINES;
        m_data[line % LINES]  = IF_inst;
        exp_ready = 1'b1; exp_inst = IF_inst; exp_ifv = 1'b0; pend = 1'b0;
      end
    end else begin
      was_ready = exp_ready;
      exp_ready = 1'b0;
      if (fetch_valid && !was_ready) begin
        line = int'(fetch_addr[17:2]);
        if (m_valid.exists(line % LINES) && m_tag[line % LINES] == line / LINES) begin
          exp_ready = 1'b1; exp_inst = m_data[line % LINES]; m_hits++;
        end else begin
          pend = 1'b1; pend_addr = {fetch_addr[31:2], 2'b00};
          exp_ifv = 1'b1; exp_ifa = pend_addr; m_misses++;
        end
      end
    end
  end

  // Compare DUT outputs with the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_live) begin
      checks++;
      if (fetch_ready !== exp_ready) begin
        errors++; $display("FAIL model_fetch_ready t=%0t got %b want %b", $time, fetch_ready, exp_ready);
      end
      if (fetch_inst !== exp_inst) begin
        errors++; $display("FAIL model_fetch_inst t=%0t got %h want %h", $time, fetch_inst, exp_inst);
      end
      if (IF_valid !== exp_ifv) begin
        errors++; $display("FAIL model_IF_valid t=%0t got %b want %b", $time, IF_valid, exp_ifv);
      end
      if (IF_addr !== exp_ifa) begin
        errors++; $display("FAIL model_IF_addr t=%0t got %h want %h", $time, IF_addr, exp_ifa);
      end
`ifdef ICACHE_STATS_EN
      if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
        errors++; $display("FAIL model_counters t=%0t got %0d/%0d want %0d/%0d", $time, hit_cnt, miss_cnt, m_hits, m_misses);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Issue a fetch; after one edge the DUT either answers (hit) or requests memory.
  task automatic fetch(input logic [31:0] a);
    fetch_valid = 1'b1; fetch_addr = a;
    tick();
  endtask

  task automatic refill(input logic [31:0] d);
    IF_send = 1'b1; IF_inst = d;
    tick();
    IF_send = 1'b0; fetch_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_rst = 1'b0; fetch_valid = 1'b0; IF_send = 1'b0;
    fetch_addr = 32'h0; IF_inst = 32'h0;
    tick(2);
    rst = 1'b0;
    chk("reset_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("reset_fetch_inst", fetch_inst, 32'h0);
    chk("reset_IF_valid", {31'h0, IF_valid}, 32'h0);
    chk("reset_IF_addr", IF_addr, 32'h0);

    // Cold miss and refill
    fetch(32'h0000_0100);
    chk("miss100_IF_valid", {31'h0, IF_valid}, 32'h1);
    chk("miss100_IF_addr", IF_addr, 32'h0000_0100);
    refill(32'h0000_0013);
    chk("fill100_ready", {31'h0, fetch_ready}, 32'h1);
    chk("fill100_inst", fetch_inst, 32'h0000_0013);
    chk("fill100_IF_valid", {31'h0, IF_valid}, 32'h0);
    tick();
    chk("fill100_pulse_end", {31'h0, fetch_ready}, 32'h0);

    // Hit on re-fetch
    fetch(32'h0000_0100);
    chk("hit100_ready", {31'h0, fetch_ready}, 32'h1);
    chk("hit100_inst", fetch_inst, 32'h0000_0013);
    chk("hit100_IF_valid", {31'h0, IF_valid}, 32'h0);
    fetch_valid = 1'b0;
`ifdef ICACHE_STATS_EN
    chk("stats_hit_cnt", hit_cnt, 32'd1);
    chk("stats_miss_cnt", miss_cnt, 32'd1);
`endif
    tick();

    // Conflict: 0x200 evicts 0x100 (same index 0)
    fetch(32'h0000_0200);
    chk("miss200_IF_valid", {31'h0, IF_valid}, 32'h1);
    chk("miss200_IF_addr", IF_addr, 32'h0000_0200);
    refill(32'hAAAA_0001);
    chk("fill200_inst", fetch_inst, 32'hAAAA_0001);
    tick();
    fetch(32'h0000_0100);
    chk("conflict100_IF_valid", {31'h0, IF_valid}, 32'h1);
    refill(32'h0000_0013);
    tick();

    // Held fetch_valid across the ready pulse: no back-to-back answer
    fetch(32'h0000_0103);
    chk("hold_hit_ready", {31'h0, fetch_ready}, 32'h1);
    tick();
    chk("hold_no_b2b", {31'h0, fetch_ready}, 32'h0);
    fetch_valid = 1'b0;
    tick();

    // Flush during a miss, then a late IF_send
    fetch(32'h0000_0300);
    chk("miss300_IF_valid", {31'h0, IF_valid}, 32'h1);
    jump_rst = 1'b1; fetch_valid = 1'b0;
    tick();
    jump_rst = 1'b0;
    chk("flush_IF_valid", {31'h0, IF_valid}, 32'h0);
    IF_send = 1'b1; IF_inst = 32'hDEAD_BEEF;
    tick();
    IF_send = 1'b0;
    chk("late_send_no_ready", {31'h0, fetch_ready}, 32'h0);
    tick();
    fetch(32'h0000_0300);
    chk("remiss300_IF_valid", {31'h0, IF_valid}, 32'h1);
    refill(32'h1234_5678);
    tick();

    // rdy low during a miss with IF_send high; fetch_addr wanders meanwhile
    fetch(32'h0000_0400);
    rdy = 1'b0; IF_send = 1'b1; IF_inst = 32'h5555_AAAA; fetch_addr = 32'h0000_0800;
    tick(3);
    chk("stall_IF_valid", {31'h0, IF_valid}, 32'h1);
    chk("stall_IF_addr", IF_addr, 32'h0000_0400);
    chk("stall_no_ready", {31'h0, fetch_ready}, 32'h0);
    rdy = 1'b1;
    tick();
    IF_send = 1'b0; fetch_valid = 1'b0;
    chk("stall_fill_inst", fetch_inst, 32'h5555_AAAA);
    tick();
    fetch(32'h0000_0400);
    chk("stall_refetch_hit", {31'h0, fetch_ready}, 32'h1);
    fetch_valid = 1'b0;
    tick();

    // jump_rst and IF_send together: line must not be written
    fetch(32'h0000_0504);
    jump_rst = 1'b1; IF_send = 1'b1; IF_inst = 32'h0BAD_0BAD; fetch_valid = 1'b0;
    tick();
    jump_rst = 1'b0; IF_send = 1'b0;
    chk("jump_send_no_ready", {31'h0, fetch_ready}, 32'h0);
    tick();
    fetch(32'h0000_0504);
    chk("jump_send_remiss", {31'h0, IF_valid}, 32'h1);
    refill(32'h0000_0504);
    tick();

    // rst in MISS abandons the miss and invalidates everything
    fetch(32'h0000_0600);
    rst = 1'b1; IF_send = 1'b1; IF_inst = 32'h6666_6666; fetch_valid = 1'b0;
    tick();
    rst = 1'b0; IF_send = 1'b0;
    chk("rst_miss_IF_valid", {31'h0, IF_valid}, 32'h0);
    tick();
    fetch(32'h0000_0100);
    chk("post_rst_miss100", {31'h0, IF_valid}, 32'h1);
    refill(32'h0000_0013);
    tick();
    fetch(32'h0000_0600);
    chk("post_rst_miss600", {31'h0, IF_valid}, 32'h1);
    refill(32'h0000_0600);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, number of index bits (64 direct-mapped one-word lines).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rdy  input  1  global ready; when low, all state and outputs hold.
REQ-005 SHALL have port jump_rst  input  1  mispredict flush; aborts any outstanding miss.
REQ-006 SHALL have port fetch_valid  input  1  fetcher requests the instruction at fetch_addr.
REQ-007 SHALL have port fetch_addr  input  32  byte address; bits [1:0] ignored; only bits [17:0] significant.
REQ-008 SHALL have port fetch_ready  output  1  one-cycle pulse: fetch_inst valid for the current request.
REQ-009 SHALL have port fetch_inst  output  32  returned instruction word.
REQ-010 SHALL have port IF_valid  output  1  miss request to the memory controller, level-held.
REQ-011 SHALL have port IF_addr  output  32  word-aligned miss address.
REQ-012 SHALL have port IF_send  input  1  memory controller one-cycle completion pulse.
REQ-013 SHALL have port IF_inst  input  32  refill word, valid when IF_send=1.

Function
REQ-014 SHALL split the address as index=addr[INDEX_BITS+1:2] and tag=addr[17:INDEX_BITS+2]; each line holds a valid bit, a tag and a 32-bit word.
REQ-015 SHALL implement states IDLE and MISS.
REQ-016 IDLE, fetch_valid, hit: SHALL pulse fetch_ready with the line data on the next cycle and remain in IDLE.
REQ-017 IDLE, fetch_valid, miss: SHALL enter MISS next cycle with IF_valid=1 and IF_addr={fetch_addr[31:2],2'b00}.
REQ-018 MISS: SHALL hold IF_valid and IF_addr until IF_send is sampled high.
REQ-019 MISS with IF_send=1: SHALL write the line (valid=1, tag, IF_inst), deassert IF_valid, pulse fetch_ready with fetch_inst=IF_inst and return to IDLE, all on the same edge; IF_valid therefore deasserts the cycle after IF_send so the controller leaves its fetch state.
REQ-020 The fetcher SHALL hold fetch_valid and fetch_addr stable until fetch_ready; the cache SHALL ignore fetch_addr changes while in MISS.
REQ-021 A fetch_ready pulse SHALL NOT be issued back-to-back for the same request; a new lookup SHALL occur only in IDLE.
REQ-022 jump_rst=1 SHALL force IDLE, IF_valid=0 and fetch_ready=0 on the next edge; line contents and valid bits SHALL be kept.
REQ-023 jump_rst and IF_send both high: jump_rst SHALL win and the line SHALL NOT be written.
REQ-024 rdy=0 SHALL freeze state, array and outputs; rst and jump_rst SHALL take priority over rdy.

Reset
REQ-025 rst SHALL clear all valid bits, set state to IDLE, and drive fetch_ready=0, fetch_inst=0, IF_valid=0 and IF_addr=0; tag and data arrays need not be cleared.
REQ-026 rst during MISS SHALL abandon the miss without writing the line.

Configuration
REQ-027 With ICACHE_STATS_EN defined, SHALL add outputs hit_cnt (32) and miss_cnt (32), incremented per lookup in IDLE, cleared only by rst, wrapping at 2^32, and held while rdy=0.
REQ-028 Without ICACHE_STATS_EN, these ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-029 The shared config include SHALL hold the state encodings ICACHE_IDLE/ICACHE_MISS and the default INDEX_BITS.
REQ-030 The cache SHALL be a single module; no sub-module is required, and the arrays SHALL be plain register arrays.

Verification
REQ-031 After rst, fetch 0x0000_0100: IF_valid=1 and IF_addr=0x100 next cycle. Respond with IF_send=1 and IF_inst=0x0000_0013: expect fetch_ready=1 with fetch_inst=0x13, and IF_valid=0, on the following cycle.
REQ-032 Re-fetch 0x100: expect fetch_ready one cycle later with 0x13 and IF_valid never asserted.
REQ-033 Conflict test with INDEX_BITS=6: fetch 0x100 then 0x200 (same index, different tag): expect a miss on 0x200; a refetch of 0x100 also misses.
REQ-034 Miss on 0x300, then jump_rst in the wait cycle, then a late IF_send=1: expect IF_valid=0, no fetch_ready, and a later fetch of 0x300 misses again.
REQ-035 Hold rdy=0 for 3 cycles during MISS with IF_send high: expect no state change; the refill completes only once rdy=1.
REQ-036 With ICACHE_STATS_EN: the sequence in REQ-031/032 yields hit_cnt=1 and miss_cnt=1.
